// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUSY_IF  = 2'd1,
        ARB_BUSY_MEM = 2'd2,
        ARB_RESP     = 2'd3
    } arb_state_e;

    // Access widths, funct3[1:0] encoding.
    localparam logic [1:0] MEMW_BYTE = 2'b00;
    localparam logic [1:0] MEMW_HALF = 2'b01;
    localparam logic [1:0] MEMW_WORD = 2'b10;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between instruction fetch and the mem stage.
// Data beats fetch, but fetch is guaranteed a grant after STARVE_LIMIT
// consecutive mem grants taken while it was waiting.
//
// Handshake: a requester raises *_req with stable fields and holds it until
// its one-cycle *_ack. On the bus side bus_req stays high with stable fields
// until the slave returns bus_ack; bus_ack is looked at only in BUSY states.
// Every output is a register, so no input reaches an output combinationally.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    input  logic        mem_we,
    input  logic [1:0]  mem_width,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    output logic [1:0]  bus_width,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  o_dbg_state
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    arb_state_e      r_state;
    arb_state_e      w_next_state;
    logic [CW-1:0]   r_starve_cnt;
    logic            w_grant_if;
    logic            w_grant_mem;
    logic            w_done_if;
    logic            w_done_mem;

    logic            r_bus_req;
    logic [31:0]     r_bus_addr;
    logic [31:0]     r_bus_wdata;
    logic            r_bus_we;
    logic [1:0]      r_bus_width;
    logic            r_if_ack;
    logic            r_mem_ack;
    logic [31:0]     r_if_rdata;
    logic [31:0]     r_mem_rdata;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: grant from IDLE, wait for the slave, one RESP cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_grant_if) begin
                    w_next_state = ARB_BUSY_IF;
                end else if (w_grant_mem) begin
                    w_next_state = ARB_BUSY_MEM;
                end
            end
            ARB_BUSY_IF:  if (bus_ack) w_next_state = ARB_RESP;
            ARB_BUSY_MEM: if (bus_ack) w_next_state = ARB_RESP;
            ARB_RESP:     w_next_state = ARB_IDLE;
            default:      w_next_state = ARB_IDLE;
        endcase
    end

    // Control decode: priority grant in IDLE and slave completion in BUSY.
    always_comb begin
        w_grant_if  = 1'b0;
        w_grant_mem = 1'b0;
        w_done_if   = (r_state == ARB_BUSY_IF)  && bus_ack;
        w_done_mem  = (r_state == ARB_BUSY_MEM) && bus_ack;
        if (r_state == ARB_IDLE) begin
            if (if_req && mem_req) begin
                // Fetch wins a contested cycle only once it has been starved.
                if (r_starve_cnt == LIMIT_C) begin
                    w_grant_if = 1'b1;
                end else begin
                    w_grant_mem = 1'b1;
                end
            end else begin
                w_grant_if  = if_req;
                w_grant_mem = mem_req;
            end
        end
    end

    // Starvation counter: counts mem grants that left fetch waiting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (w_grant_mem && if_req) begin
            if (r_starve_cnt != LIMIT_C) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else if (w_grant_if || w_grant_mem) begin
            r_starve_cnt <= '0;
        end
    end

    // Bus request registers: load the winner at grant, drop req on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bus_req   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_we    <= 1'b0;
            r_bus_width <= MEMW_BYTE;
        end else if (w_grant_if) begin
            r_bus_req   <= 1'b1;
            r_bus_addr  <= if_addr;
            r_bus_wdata <= '0;
            r_bus_we    <= 1'b0;
            r_bus_width <= MEMW_WORD;
        end else if (w_grant_mem) begin
            r_bus_req   <= 1'b1;
            r_bus_addr  <= mem_addr;
            r_bus_wdata <= mem_wdata;
            r_bus_we    <= mem_we;
            r_bus_width <= mem_width;
        end else if (w_done_if || w_done_mem) begin
            r_bus_req   <= 1'b0;
        end
    end

    // Response registers: one-cycle ack and read data held between acks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_if_ack    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            r_if_ack  <= w_done_if;
            r_mem_ack <= w_done_mem;
            if (w_done_if) begin
                r_if_rdata <= bus_rdata;
            end
            if (w_done_mem) begin
                r_mem_rdata <= bus_rdata;
            end
        end
    end

    assign bus_req     = r_bus_req;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign bus_we      = r_bus_we;
    assign bus_width   = r_bus_width;
    assign if_ack      = r_if_ack;
    assign if_rdata    = r_if_rdata;
    assign mem_ack     = r_mem_ack;
    assign mem_rdata   = r_mem_rdata;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int LIMIT = 2;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [1:0]  mem_width;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [1:0]  bus_width;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Reference model state (transaction level).
    int          starve_m;
    logic        win_if;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_we;
    logic [1:0]  e_width;
    logic [31:0] e_rdata;
    logic [31:0] last_if_rdata;
    logic [31:0] last_mem_rdata;
    int          wait_cycles;
    int          exp_fetch [6] = '{0, 0, 1, 0, 0, 1};

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_width  (mem_width),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .bus_req    (bus_req),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_we     (bus_we),
        .bus_width  (bus_width),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .o_dbg_state(dbg_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are settled and inputs may be driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0;
        mem_addr = '0; mem_we = 1'b0; mem_width = 2'b00; mem_wdata = '0;
        bus_ack = 1'b0; bus_rdata = '0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(dbg_state), 32'(ARB_IDLE));
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_width", 32'(bus_width), 32'd0);
        check("rst_bus_addr", bus_addr, 32'd0);
        check("rst_bus_wdata", bus_wdata, 32'd0);
        check("rst_if_ack", 32'(if_ack), 32'd0);
        check("rst_mem_ack", 32'(mem_ack), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        reset_n = 1'b1;
        step();

        // Fetch alone, slave acks in cycle 3.
        if_req = 1'b1; if_addr = 32'h100;
        step();
        check("f_c1_req", 32'(bus_req), 32'd1);
        check("f_c1_addr", bus_addr, 32'h100);
        check("f_c1_we", 32'(bus_we), 32'd0);
        check("f_c1_width", 32'(bus_width), 32'(MEMW_WORD));
        check("f_c1_state", 32'(dbg_state), 32'(ARB_BUSY_IF));
        step();
        check("f_c2_req", 32'(bus_req), 32'd1);
        step();
        check("f_c3_req", 32'(bus_req), 32'd1);
        check("f_c3_noack", 32'(if_ack), 32'd0);
        bus_ack = 1'b1; bus_rdata = 32'h0000_0013;
        step();
        check("f_c4_ack", 32'(if_ack), 32'd1);
        check("f_c4_rdata", if_rdata, 32'h0000_0013);
        check("f_c4_req", 32'(bus_req), 32'd0);
        check("f_c4_memack", 32'(mem_ack), 32'd0);
        check("f_c4_state", 32'(dbg_state), 32'(ARB_RESP));
        bus_ack = 1'b0; bus_rdata = '0; if_req = 1'b0;
        step();
        check("f_c5_state", 32'(dbg_state), 32'(ARB_IDLE));
        check("f_c5_ack", 32'(if_ack), 32'd0);
        check("f_c5_hold", if_rdata, 32'h0000_0013);

        // Store alone, zero-wait slave.
        mem_req = 1'b1; mem_addr = 32'h2000; mem_we = 1'b1; mem_width = MEMW_BYTE; mem_wdata = 32'hAB;
        step();
        check("s_c1_req", 32'(bus_req), 32'd1);
        check("s_c1_addr", bus_addr, 32'h2000);
        check("s_c1_we", 32'(bus_we), 32'd1);
        check("s_c1_width", 32'(bus_width), 32'(MEMW_BYTE));
        check("s_c1_wdata", bus_wdata, 32'hAB);
        check("s_c1_state", 32'(dbg_state), 32'(ARB_BUSY_MEM));
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_0001;
        step();
        check("s_c2_ack", 32'(mem_ack), 32'd1);
        check("s_c2_rdata", mem_rdata, 32'hCAFE_0001);
        check("s_c2_ifack", 32'(if_ack), 32'd0);
        check("s_c2_req", 32'(bus_req), 32'd0);
        bus_ack = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        step();
        check("s_c3_state", 32'(dbg_state), 32'(ARB_IDLE));
        check("s_c3_ack", 32'(mem_ack), 32'd0);

        // Both always requesting: mem, mem, fetch, mem, mem, fetch.
        if_req = 1'b1; if_addr = 32'h1000;
        mem_req = 1'b1; mem_addr = 32'h2004; mem_we = 1'b0; mem_width = MEMW_WORD;
        for (int i = 0; i < 6; i++) begin
            step();
            check("st_req", 32'(bus_req), 32'd1);
            check("st_grant", bus_addr, (exp_fetch[i] != 0) ? 32'h1000 : 32'h2004);
            bus_ack = 1'b1; bus_rdata = 32'(i);
            step();
            check("st_if_ack", 32'(if_ack), 32'(exp_fetch[i] != 0));
            check("st_mem_ack", 32'(mem_ack), 32'(exp_fetch[i] == 0));
            bus_ack = 1'b0;
            step();
        end
        if_req = 1'b0; mem_req = 1'b0;
        step();

        // Asynchronous reset while a data transaction is in flight.
        mem_req = 1'b1; mem_addr = 32'h3000; mem_we = 1'b1; mem_width = MEMW_HALF; mem_wdata = 32'h55;
        step();
        check("r_busy", 32'(dbg_state), 32'(ARB_BUSY_MEM));
        if_req = 1'b1; if_addr = 32'h400;
        #2;
        reset_n = 1'b0;
        #1;
        check("r_req_drop", 32'(bus_req), 32'd0);
        check("r_if_ack", 32'(if_ack), 32'd0);
        check("r_mem_ack", 32'(mem_ack), 32'd0);
        check("r_state", 32'(dbg_state), 32'(ARB_IDLE));
        check("r_mem_rdata", mem_rdata, 32'd0);
        mem_req = 1'b0; mem_we = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        check("r_after_req", 32'(bus_req), 32'd1);
        check("r_after_state", 32'(dbg_state), 32'(ARB_BUSY_IF));
        check("r_after_addr", bus_addr, 32'h400);
        bus_ack = 1'b1; bus_rdata = 32'h77;
        step();
        check("r_after_ack", 32'(if_ack), 32'd1);
        check("r_after_rdata", if_rdata, 32'h77);
        check("r_after_memack", 32'(mem_ack), 32'd0);
        bus_ack = 1'b0; if_req = 1'b0;
        step();

        // Spurious slave ack while IDLE.
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        step();
        check("sp_if_ack", 32'(if_ack), 32'd0);
        check("sp_mem_ack", 32'(mem_ack), 32'd0);
        check("sp_state", 32'(dbg_state), 32'(ARB_IDLE));
        check("sp_req", 32'(bus_req), 32'd0);
        check("sp_rdata", if_rdata, 32'h77);
        bus_ack = 1'b0;

        // Fetch request held through RESP starts exactly one new transaction.
        if_req = 1'b1; if_addr = 32'h500;
        step();
        bus_ack = 1'b1; bus_rdata = 32'h111;
        step();
        check("h_ack1", 32'(if_ack), 32'd1);
        bus_ack = 1'b0; if_addr = 32'h600;
        step();
        check("h_idle_state", 32'(dbg_state), 32'(ARB_IDLE));
        check("h_idle_req", 32'(bus_req), 32'd0);
        check("h_idle_ack", 32'(if_ack), 32'd0);
        step();
        check("h_new_req", 32'(bus_req), 32'd1);
        check("h_new_addr", bus_addr, 32'h600);
        bus_ack = 1'b1; bus_rdata = 32'h222;
        step();
        check("h_ack2", 32'(if_ack), 32'd1);
        check("h_rdata2", if_rdata, 32'h222);
        bus_ack = 1'b0; if_req = 1'b0;
        step();
        step();
        check("h_no_extra_req", 32'(bus_req), 32'd0);
        check("h_no_extra_state", 32'(dbg_state), 32'(ARB_IDLE));

        // Randomized traffic against the reference model.
        starve_m = 0;
        last_if_rdata = 32'h222;
        last_mem_rdata = 32'hCAFE_0001;
        for (int t = 0; t < 60; t++) begin
            if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req = 1'b1; if_addr = $urandom();
            end
            if (!mem_req && $urandom_range(0, 2) != 0) begin
                mem_req = 1'b1; mem_addr = $urandom(); mem_we = 1'($urandom_range(0, 1));
                mem_width = 2'($urandom_range(0, 2)); mem_wdata = $urandom();
            end
            if (!if_req && !mem_req) begin
                step();
                check("rnd_idle_state", 32'(dbg_state), 32'(ARB_IDLE));
                check("rnd_idle_req", 32'(bus_req), 32'd0);
                continue;
            end
            // Data wins, unless fetch has already sat through LIMIT mem grants.
            win_if = if_req && (!mem_req || starve_m >= LIMIT);
            if (!win_if && if_req) starve_m = (starve_m + 1 > LIMIT) ? LIMIT : starve_m + 1;
            else starve_m = 0;
            e_addr  = win_if ? if_addr : mem_addr;
            e_wdata = mem_wdata;
            e_we    = win_if ? 1'b0 : mem_we;
            e_width = win_if ? MEMW_WORD : mem_width;
            step();
            check("rnd_grant_state", 32'(dbg_state), win_if ? 32'(ARB_BUSY_IF) : 32'(ARB_BUSY_MEM));
            check("rnd_req", 32'(bus_req), 32'd1);
            check("rnd_addr", bus_addr, e_addr);
            check("rnd_we", 32'(bus_we), 32'(e_we));
            check("rnd_width", 32'(bus_width), 32'(e_width));
            if (!win_if) check("rnd_wdata", bus_wdata, e_wdata);
            wait_cycles = $urandom_range(0, 3);
            for (int k = 0; k < wait_cycles; k++) begin
                if (!if_req) if_addr = $urandom();
                if (!mem_req) mem_addr = $urandom();
                step();
                check("rnd_hold_req", 32'(bus_req), 32'd1);
                check("rnd_hold_addr", bus_addr, e_addr);
                check("rnd_hold_ack", 32'(if_ack | mem_ack), 32'd0);
            end
            bus_ack = 1'b1; bus_rdata = $urandom();
            exp_q.push_back(bus_rdata);
            step();
            e_rdata = exp_q.pop_front();
            if (win_if) last_if_rdata = e_rdata;
            else last_mem_rdata = e_rdata;
            check("rnd_if_ack", 32'(if_ack), 32'(win_if));
            check("rnd_mem_ack", 32'(mem_ack), 32'(!win_if));
            check("rnd_if_rdata", if_rdata, last_if_rdata);
            check("rnd_mem_rdata", mem_rdata, last_mem_rdata);
            check("rnd_resp_req", 32'(bus_req), 32'd0);
            bus_ack = 1'($urandom_range(0, 3) == 0);
            if (win_if) if_req = 1'b0;
            else mem_req = 1'b0;
            step();
            bus_ack = 1'b0;
            check("rnd_back_idle", 32'(dbg_state), 32'(ARB_IDLE));
            check("rnd_idle_acks", 32'(if_ack | mem_ack), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
